// File: rtl/bank_burst_ctrl.sv
// bank_burst_ctrl: sequences one whole-burst request onto a DRAM bank, one beat per clk.
module bank_burst_ctrl #(
  parameter int DEVICE_WIDTH = 4,
  parameter int COLS         = 1024,
  parameter int BL           = 8,
  parameter int CHWIDTH      = 5,
  parameter int RD_LAT       = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_wr,
  input  logic [CHWIDTH-1:0]           req_row,
  input  logic [$clog2(COLS)-1:0]      req_col,
  input  logic [DEVICE_WIDTH*BL-1:0]   req_wdata,
  output logic                         done,
  output logic [DEVICE_WIDTH*BL-1:0]   rdata,
  output logic                         done_wr,
  output logic                         rd_o_wr,
  output logic [CHWIDTH-1:0]           row,
  output logic [$clog2(COLS)-1:0]      column,
  output logic [DEVICE_WIDTH-1:0]      dqin,
  input  logic [DEVICE_WIDTH-1:0]      dqout
);
  localparam int CA = $clog2(COLS);
  localparam int CW = $clog2(BL + RD_LAT + 1);
  localparam int DW = DEVICE_WIDTH * BL;
  localparam logic [CA-1:0] MASK = CA'(BL - 1);
  typedef enum logic [1:0] {IDLE, WRITE, READ, RDRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, idx;
  logic [CHWIDTH-1:0] lrow_q, lrow_d, row_q, row_d;
  logic [CA-1:0] lcol_q, lcol_d, column_q, column_d;
  logic [DW-1:0] lwd_q, lwd_d, shadow_q, shadow_d, rdata_q, rdata_d;
  logic [DEVICE_WIDTH-1:0] dqin_q, dqin_d;
  logic req_ready_q, req_ready_d, done_q, done_d, done_wr_q, done_wr_d, rd_o_wr_q, rd_o_wr_d;
  logic accept, cap, busy_d;
  always_comb begin
    accept = req_valid && req_ready_q;
    state_d = state_q;
    cnt_d = accept ? '0 : (state_q == IDLE ? cnt_q : cnt_q + CW'(1));
    lrow_d = accept ? req_row : lrow_q;
    lcol_d = accept ? req_col : lcol_q;
    lwd_d = accept ? req_wdata : lwd_q;
    // cnt_q counts cycles since accept; beat i returns RD_LAT cycles after it was driven
    idx = cnt_q - CW'(RD_LAT);
    cap = (state_q == READ || state_q == RDRAIN) && cnt_q >= CW'(RD_LAT);
    shadow_d = shadow_q;
    for (int b = 0; b < BL; b++)
      if (cap && idx == CW'(b)) shadow_d[b*DEVICE_WIDTH +: DEVICE_WIDTH] = dqout;
    done_d = 1'b0;
    done_wr_d = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_wr ? WRITE : READ;
      WRITE:   if (cnt_q == CW'(BL - 1)) begin
        state_d = IDLE;
        done_d = 1'b1;
        done_wr_d = 1'b1;
      end
      READ:    if (cnt_q == CW'(BL - 1)) state_d = RDRAIN;
      RDRAIN:  if (cnt_q == CW'(BL - 1 + RD_LAT)) begin
        state_d = IDLE;
        done_d = 1'b1;
        rdata_d = shadow_d;
      end
      default: state_d = IDLE;
    endcase
    // bank-facing outputs are registered from next state, so beat 0 appears the cycle after accept
    busy_d = state_d == WRITE || state_d == READ;
    req_ready_d = state_d == IDLE;
    rd_o_wr_d = state_d == WRITE;
    row_d = busy_d ? lrow_d : '0;
    column_d = busy_d ? ((lcol_d & ~MASK) | ((lcol_d + CA'(cnt_d)) & MASK)) : '0;
    dqin_d = state_d == WRITE ? DEVICE_WIDTH'(lwd_d >> (cnt_d * DEVICE_WIDTH)) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      lrow_q <= '0;
      lcol_q <= '0;
      lwd_q <= '0;
      shadow_q <= '0;
      rdata_q <= '0;
      req_ready_q <= 1'b1;
      done_q <= 1'b0;
      done_wr_q <= 1'b0;
      rd_o_wr_q <= 1'b0;
      row_q <= '0;
      column_q <= '0;
      dqin_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      lrow_q <= lrow_d;
      lcol_q <= lcol_d;
      lwd_q <= lwd_d;
      shadow_q <= shadow_d;
      rdata_q <= rdata_d;
      req_ready_q <= req_ready_d;
      done_q <= done_d;
      done_wr_q <= done_wr_d;
      rd_o_wr_q <= rd_o_wr_d;
      row_q <= row_d;
      column_q <= column_d;
      dqin_q <= dqin_d;
    end
  end
  assign req_ready = req_ready_q;
  assign done = done_q;
  assign done_wr = done_wr_q;
  assign rdata = rdata_q;
  assign rd_o_wr = rd_o_wr_q;
  assign row = row_q;
  assign column = column_q;
  assign dqin = dqin_q;
endmodule

// File: tb/tb_bank_burst_ctrl.sv
// tb_bank_burst_ctrl: directed checks of bank_burst_ctrl against a 1-cycle-latency bank model.
module tb_bank_burst_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic req_wr = 1'b0;
  logic [4:0] req_row = '0;
  logic [9:0] req_col = '0;
  logic [31:0] req_wdata = '0;
  logic done, done_wr, rd_o_wr;
  logic [31:0] rdata;
  logic [4:0] row;
  logic [9:0] column;
  logic [3:0] dqin, dqout;
  logic [3:0] mem [32768];
  logic [31:0] last_rd = '0;
  int n_assert = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  bank_burst_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata), .done(done), .rdata(rdata),
    .done_wr(done_wr), .rd_o_wr(rd_o_wr), .row(row), .column(column), .dqin(dqin), .dqout(dqout)
  );
  always @(posedge clk) begin
    if (rd_o_wr) mem[{row, column}] <= dqin;
    dqout <= mem[{row, column}];
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [9:0] colx(input logic [9:0] c, input int i);
    return (c & 10'h3F8) | ((c + 10'(i)) & 10'h007);
  endfunction
  function automatic logic [3:0] beat(input logic [31:0] wd, input int i);
    return 4'(wd >> (4 * i));
  endfunction
  task automatic run_burst(input logic wr, input logic [4:0] r, input logic [9:0] c,
                           input logic [31:0] wd, input logic [31:0] exp_rd);
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_row = r; req_col = c; req_wdata = wd;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk("beat_rd_o_wr", rd_o_wr, wr);
      chk("beat_row", row, r);
      chk("beat_column", column, colx(c, i));
      chk("beat_dqin", dqin, wr ? beat(wd, i) : 4'h0);
      chk("beat_ready", req_ready, 0);
      chk("beat_done", done, 0);
    end
    if (!wr) begin
      @(negedge clk);
      chk("drain_done", done, 0);
      chk("drain_ready", req_ready, 0);
      chk("drain_bus", {rd_o_wr, row, column, dqin}, 0);
      chk("drain_rdata_held", rdata, last_rd);
    end
    @(negedge clk);
    chk("done", done, 1);
    chk("done_wr", done_wr, wr);
    chk("done_ready", req_ready, 1);
    chk("done_bus", {rd_o_wr, row, column, dqin}, 0);
    if (!wr) begin
      last_rd = exp_rd;
      chk("rdata", rdata, exp_rd);
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask
  initial begin
    // 1: reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_done", {done, done_wr}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bus", {rd_o_wr, row, column, dqin}, 0);
    rst = 1'b0;
    // 2-3: write then read back at column 0
    run_burst(1'b1, 5'd1, 10'd0, 32'h87654321, 32'h0);
    run_burst(1'b0, 5'd1, 10'd0, 32'h0, 32'h87654321);
    // 4: wrap inside the last BL-aligned block
    run_burst(1'b1, 5'd2, 10'd1021, 32'hA5C31E7F, 32'h0);
    run_burst(1'b0, 5'd2, 10'd1021, 32'h0, 32'hA5C31E7F);
    // 5: req_valid held through a write; busy-time field changes ignored; back-to-back read
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_row = 5'd3; req_col = 10'd8; req_wdata = 32'h0F1E2D3C;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_wr = 1'b0; req_wdata = 32'hFFFFFFFF;
      chk("b2b_ready_busy", req_ready, 0);
      chk("b2b_rd_o_wr", rd_o_wr, 1);
      chk("b2b_column", column, 10'(8 + i));
      chk("b2b_dqin", dqin, beat(32'h0F1E2D3C, i));
    end
    @(negedge clk);
    chk("b2b_done", {done, done_wr, req_ready}, 3'b111);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk("b2b_rd_ready", req_ready, 0);
      chk("b2b_rd_bus", {rd_o_wr, row, column, dqin}, {1'b0, 5'd3, 10'(8 + i), 4'h0});
      chk("b2b_rd_done", done, 0);
    end
    @(negedge clk);
    chk("b2b_drain_done", done, 0);
    @(negedge clk);
    chk("b2b_rd_done", {done, done_wr}, 2'b10);
    chk("b2b_rdata", rdata, 32'h0F1E2D3C);
    // 6: reset during read beat 3
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_row = 5'd1; req_col = 10'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort_column", column, 10'(i));
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_bus", {rd_o_wr, row, column, dqin}, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_done", done, 0);
    chk("abort_rdata", rdata, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", {done, rd_o_wr, req_ready}, 3'b001);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
